// File: rtl/dlfloat_pkg.sv
// -----------------------------------------------------------------------------
// dlfloat_pkg
// Shared definitions for the DLFloat16 dot-product scheduler: operand width,
// a few DLFloat16 constants and the scheduler state encoding.
// -----------------------------------------------------------------------------
package dlfloat_pkg;

    localparam int DLF_W = 16;

    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
    localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
    localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_RESULT
    } sched_state_t;

endpackage

// File: rtl/dlfloat_rr_arb.sv
// -----------------------------------------------------------------------------
// dlfloat_rr_arb
// Two-way round-robin arbiter. A lone requester always wins; when both request,
// the one that was NOT granted last time wins.
//   req        : request vector, one bit per requester
//   last_grant : index of the requester served most recently
//   gnt        : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module dlfloat_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dlfloat_dot_sched.sv
// -----------------------------------------------------------------------------
// dlfloat_dot_sched
// Shares one external DLFloat16 multiply-accumulate unit between two
// requesters. A granted job clears the accumulator, streams its N operand
// pairs into the MAC, waits out the MAC pipeline and returns the accumulated
// value tagged with the requester id.
//   clk, rst_n          : clock, asynchronous active-low reset
//   job_valid/job_len   : per-requester job request and pair count
//   job_ready           : one-hot job acceptance (IDLE only)
//   op_valid/op_a/op_b  : per-requester operand stream (16-bit lanes)
//   op_ready            : one-hot operand acceptance (granted lane, STREAM)
//   mac_clr/mac_en      : accumulator clear pulse / accumulate enable
//   mac_a/mac_b         : registered operands to the MAC
//   mac_acc             : accumulator value returned by the MAC
//   res_valid/res_data/res_id/res_ready : result handshake
//   busy                : high whenever a job is in progress
// -----------------------------------------------------------------------------
module dlfloat_dot_sched
    import dlfloat_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           job_valid,
    input  logic [2*LEN_W-1:0]   job_len,
    output logic [1:0]           job_ready,
    input  logic [1:0]           op_valid,
    input  logic [2*DLF_W-1:0]   op_a,
    input  logic [2*DLF_W-1:0]   op_b,
    output logic [1:0]           op_ready,
    output logic                 mac_clr,
    output logic                 mac_en,
    output logic [DLF_W-1:0]     mac_a,
    output logic [DLF_W-1:0]     mac_b,
    input  logic [DLF_W-1:0]     mac_acc,
    output logic                 res_valid,
    output logic [DLF_W-1:0]     res_data,
    output logic                 res_id,
    input  logic                 res_ready,
    output logic                 busy
);

    // Drain counter must be able to hold MAC_LAT (sized for MAC_LAT = 0 too).
    localparam int                DCNT_W     = $clog2(MAC_LAT + 2);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(MAC_LAT);

    sched_state_t      state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;
    logic [DCNT_W-1:0] dcnt_reg, dcnt_next;
    logic              id_reg, id_next;
    logic              last_grant_reg, last_grant_next;
    logic              mac_en_reg, mac_en_next;
    logic [DLF_W-1:0]  mac_a_reg, mac_a_next;
    logic [DLF_W-1:0]  mac_b_reg, mac_b_next;
    logic [DLF_W-1:0]  res_data_reg, res_data_next;
    logic              res_id_reg, res_id_next;

    logic [1:0]        gnt;
    logic [LEN_W-1:0]  lane_len [2];
    logic [DLF_W-1:0]  lane_a   [2];
    logic [DLF_W-1:0]  lane_b   [2];

    dlfloat_rr_arb u_arb (
        .req        (job_valid),
        .last_grant (last_grant_reg),
        .gnt        (gnt)
    );

    // Per-lane unpacking and one-hot handshake outputs. job_ready is gated by
    // rst_n so that nothing is acknowledged while reset is held, even though
    // the state register already sits in IDLE.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_len[gi]  = job_len[gi*LEN_W +: LEN_W];
            assign lane_a[gi]    = op_a[gi*DLF_W +: DLF_W];
            assign lane_b[gi]    = op_b[gi*DLF_W +: DLF_W];
            assign op_ready[gi]  = (state_reg == ST_STREAM) && (id_reg == 1'(gi));
            assign job_ready[gi] = rst_n && (state_reg == ST_IDLE) && gnt[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            len_reg        <= '0;
            cnt_reg        <= '0;
            dcnt_reg       <= '0;
            id_reg         <= 1'b0;
            last_grant_reg <= 1'b1;
            mac_en_reg     <= 1'b0;
            mac_a_reg      <= '0;
            mac_b_reg      <= '0;
            res_data_reg   <= '0;
            res_id_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            cnt_reg        <= cnt_next;
            dcnt_reg       <= dcnt_next;
            id_reg         <= id_next;
            last_grant_reg <= last_grant_next;
            mac_en_reg     <= mac_en_next;
            mac_a_reg      <= mac_a_next;
            mac_b_reg      <= mac_b_next;
            res_data_reg   <= res_data_next;
            res_id_reg     <= res_id_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        cnt_next        = cnt_reg;
        dcnt_next       = dcnt_reg;
        id_next         = id_reg;
        last_grant_next = last_grant_reg;
        // MAC inputs are zero and enable low unless a pair is handed over.
        mac_en_next     = 1'b0;
        mac_a_next      = '0;
        mac_b_next      = '0;
        res_data_next   = res_data_reg;
        res_id_next     = res_id_reg;

        case (state_reg)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    len_next   = lane_len[gnt[1]];
                    id_next    = gnt[1];
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_next = '0;
                if (len_reg == '0) begin
                    // Empty job: nothing to accumulate, report zero directly.
                    res_data_next = DLF_ZERO;
                    res_id_next   = id_reg;
                    state_next    = ST_RESULT;
                end else begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (op_valid[id_reg]) begin
                    mac_en_next = 1'b1;
                    mac_a_next  = lane_a[id_reg];
                    mac_b_next  = lane_b[id_reg];
                    cnt_next    = cnt_reg + LEN_W'(1);
                    if (cnt_reg == len_reg - LEN_W'(1)) begin
                        dcnt_next  = '0;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last pair is being issued in the first DRAIN cycle; the
                // accumulator is final MAC_LAT cycles later.
                if (dcnt_reg == DRAIN_LAST) begin
                    res_data_next = mac_acc;
                    res_id_next   = id_reg;
                    state_next    = ST_RESULT;
                end else begin
                    dcnt_next = dcnt_reg + DCNT_W'(1);
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    last_grant_next = id_reg;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mac_clr   = (state_reg == ST_CLEAR);
    assign mac_en    = mac_en_reg;
    assign mac_a     = mac_a_reg;
    assign mac_b     = mac_b_reg;
    assign res_valid = (state_reg == ST_RESULT);
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dlfloat_dot_sched.sv
// -----------------------------------------------------------------------------
// tb_dlfloat_dot_sched
// Directed bench for dlfloat_dot_sched with a behavioural two-stage MAC.
// -----------------------------------------------------------------------------
module tb_dlfloat_dot_sched;

    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         job_valid = 2'b00;
    logic [2*LEN_W-1:0] job_len = '0;
    logic [1:0]         job_ready;
    logic [1:0]         op_valid = 2'b00;
    logic [31:0]        op_a = '0;
    logic [31:0]        op_b = '0;
    logic [1:0]         op_ready;
    logic               mac_clr;
    logic               mac_en;
    logic [15:0]        mac_a;
    logic [15:0]        mac_b;
    logic [15:0]        mac_acc;
    logic               res_valid;
    logic [15:0]        res_data;
    logic               res_id;
    logic               res_ready = 1'b0;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int en_total = 0;
    int clr_total = 0;

    logic [56:0] all_out;
    assign all_out = {job_ready, op_ready, mac_clr, mac_en, mac_a, mac_b,
                      res_valid, res_data, res_id, busy};

    always #5 clk = ~clk;

    dlfloat_dot_sched #(
        .LEN_W   (LEN_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .op_valid  (op_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ready  (op_ready),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // ---------------- DLFloat16 helpers (1 sign, 6 exp bias 31, 9 frac) -----
    function automatic real dlf_to_real(input logic [15:0] x);
        real m;
        int  e;
        if (x[14:0] == 15'd0) return 0.0;
        e = int'(x[14:9]) - 31;
        m = 1.0 + real'(int'(x[8:0])) / 512.0;
        while (e > 0) begin m = m * 2.0; e = e - 1; end
        while (e < 0) begin m = m / 2.0; e = e + 1; end
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] real_to_dlf(input real r);
        real        m;
        int         e;
        logic       s;
        logic [8:0] f;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 31;
        while (m >= 2.0) begin m = m / 2.0; e = e + 1; end
        while (m < 1.0)  begin m = m * 2.0; e = e - 1; end
        f = 9'(int'((m - 1.0) * 512.0));
        return {s, 6'(e), f};
    endfunction

    // Behavioural MAC: product registered, then accumulated; an enable pulse
    // becomes visible on mac_acc MAC_LAT (=2) cycles later.
    real  prod_r = 0.0;
    real  acc_r = 0.0;
    logic en_d = 1'b0;
    always @(posedge clk) begin
        en_d   <= mac_en;
        prod_r <= dlf_to_real(mac_a) * dlf_to_real(mac_b);
        if (mac_clr) acc_r <= 0.0;
        else if (en_d) acc_r <= acc_r + prod_r;
    end
    assign mac_acc = real_to_dlf(acc_r);

    // Cycle and pulse counters.
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (mac_en)  en_total  <= en_total + 1;
        if (mac_clr) clr_total <= clr_total + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        int          len;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic [7:0]  pat;    // op_valid pattern per STREAM cycle, bit k first
        int          hold;   // cycles of res_ready low while result shown
        logic        other;  // keep the other requester's job_valid high
    } vec_t;

    // Starts at a negedge in IDLE; returns one cycle after the result handshake.
    task automatic run_job(input vec_t v);
        int   t, k, sent, t_acc, en0, clr0, lat, exp_lat;
        int   o;
        logic other_rdy;
        o    = 1 - v.id;
        en0  = en_total;
        clr0 = clr_total;
        job_valid[v.id] = 1'b1;
        job_valid[o]    = v.other;
        job_len = {LEN_W'(v.len), LEN_W'(v.len)};
        op_a[v.id*16 +: 16] = v.a;
        op_b[v.id*16 +: 16] = v.b;
        #1;
        t = 0;
        while (job_ready[v.id] !== 1'b1 && t < 50) begin
            @(negedge clk); #1; t = t + 1;
        end
        check("grant", 64'(job_ready), 64'(1) << v.id);
        if (t >= 50) begin
            job_valid = 2'b00;
            return;
        end
        t_acc = cycle_cnt;
        @(negedge clk);
        job_valid[v.id] = 1'b0;
        sent = 0; k = 0; t = 0; other_rdy = 1'b0;
        while (sent < v.len && t < 200) begin
            #1;
            if (op_ready[o]) other_rdy = 1'b1;
            if (op_ready[v.id]) begin
                op_valid[v.id] = v.pat[k % 8];
                if (v.pat[k % 8]) sent = sent + 1;
                k = k + 1;
            end else begin
                op_valid[v.id] = 1'b0;
            end
            @(negedge clk);
            t = t + 1;
        end
        op_valid[v.id] = 1'b0;
        if (t >= 200) check("stream_timeout", 64'(sent), 64'(v.len));
        #1;
        t = 0;
        while (res_valid !== 1'b1 && t < 50) begin
            @(negedge clk); #1; t = t + 1;
        end
        lat     = cycle_cnt - t_acc;
        exp_lat = (v.len == 0) ? 2 : k + MAC_LAT + 3;
        check("res_valid", 64'(res_valid), 64'd1);
        check("latency", 64'(lat), 64'(exp_lat));
        check("res_data", 64'(res_data), 64'(v.exp));
        check("res_id", 64'(res_id), 64'(v.id));
        check("mac_en_count", 64'(en_total - en0), 64'(v.len));
        check("mac_clr_count", 64'(clr_total - clr0), 64'd1);
        check("other_op_ready", 64'(other_rdy), 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk); #1;
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_data", 64'(res_data), 64'(v.exp));
            check("hold_id", 64'(res_id), 64'(v.id));
            check("hold_no_grant", 64'(job_ready), 64'd0);
        end
        $display("job id=%0d len=%0d result=%h res_id=%0d latency=%0d", v.id, v.len, res_data, res_id, lat);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("idle_after_result", 64'(busy), 64'd0);
    endtask

    vec_t vecs[8];
    vec_t tie_v;

    initial begin
        //           id len  a         b         exp       pat    hold other
        vecs[0] = '{0, 3, 16'h3E00, 16'h4000, 16'h4300, 8'hFF, 0, 1'b0};
        vecs[1] = '{1, 2, 16'h4000, 16'h4000, 16'h4400, 8'hFF, 0, 1'b0};
        vecs[2] = '{0, 0, 16'h3E00, 16'h4000, 16'h0000, 8'hFF, 0, 1'b0};
        vecs[3] = '{0, 3, 16'h3E00, 16'h4000, 16'h4300, 8'h19, 0, 1'b0};
        vecs[4] = '{1, 4, 16'h3F00, 16'h4000, 16'h4500, 8'hFF, 0, 1'b0};
        vecs[5] = '{0, 1, 16'hBE00, 16'h4000, 16'hC000, 8'hFF, 5, 1'b1};
        vecs[6] = '{1, 1, 16'h3E00, 16'h3E00, 16'h3E00, 8'hFF, 0, 1'b0};
        vecs[7] = '{0, 2, 16'h3E00, 16'h4000, 16'h4200, 8'hFF, 0, 1'b0};

        // Reset state.
        @(negedge clk); @(negedge clk); #1;
        check("reset_outputs", 64'(all_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i]);
        end

        // Reset in the middle of a stream (last grant currently req0).
        job_len = {8'd4, 8'd4};
        op_a[15:0] = 16'h3E00;
        op_b[15:0] = 16'h4000;
        job_valid = 2'b01;
        #1;
        check("rst_seq_grant", 64'(job_ready), 64'd1);
        @(negedge clk);
        job_valid = 2'b00;
        @(negedge clk);
        op_valid = 2'b01;
        #1;
        check("rst_seq_stream", 64'({busy, op_ready}), 64'b101);
        @(negedge clk);
        @(negedge clk);
        job_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("rst_outputs_zero", 64'(all_out), 64'd0);
        op_valid = 2'b00;
        @(negedge clk); #1;
        check("rst_outputs_held", 64'(all_out), 64'd0);
        $display("reset asserted mid-stream, outputs=%h", all_out);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesting after reset: req0, req1, req0, then drain req1.
        tie_v = '{0, 1, 16'h3E00, 16'h3E00, 16'h3E00, 8'hFF, 0, 1'b1};
        run_job(tie_v);
        tie_v.id = 1;
        run_job(tie_v);
        tie_v.id = 0;
        run_job(tie_v);
        tie_v.id = 1;
        tie_v.other = 1'b0;
        run_job(tie_v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
